// File: rtl/uart_tx_arbiter_if.sv
// Bundle of the requester-side and UART TX FIFO side signals of the TX arbiter.
interface uart_tx_arbiter_if #(
  parameter int NREQ = 3,
  parameter int RR_W = 3
);
  logic [NREQ-1:0]    req;
  logic [NREQ*24-1:0] msg;
  logic [NREQ*2-1:0]  len;
  logic [NREQ-1:0]    done;
  logic               tx_full;
  logic               tx_write;
  logic [7:0]         tx_data;
  logic               busy;
  logic [RR_W-1:0]    grant_id;

  modport master (
    input  req, msg, len, tx_full,
    output done, tx_write, tx_data, busy, grant_id
  );

  modport slave (
    output req, msg, len, tx_full,
    input  done, tx_write, tx_data, busy, grant_id
  );
endinterface

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter writing atomic 1..3 byte messages into a shared UART TX FIFO.
// Optional MIDI running-status compression is enabled by defining MIDI_RUNNING_STATUS_EN.
module uart_tx_arbiter #(
  parameter int NREQ = 3,
  parameter int RR_W = 3
) (
  input logic               clk96,
  input logic               rst,
  uart_tx_arbiter_if.master bus
);

  typedef enum logic [1:0] {IDLE, SEND, DONE} state_t;

  state_t          r_state, w_nextState;
  logic [RR_W-1:0] r_rrPtr, r_grantId, w_pick;
  logic [23:0]     r_msg, w_selMsg;
  logic [1:0]      r_len, r_idx, w_selLen, w_startIdx;
  logic [NREQ-1:0] r_done;
  logic            w_found, w_txWrite, w_lastByte;
  logic [7:0]      w_txData;
`ifdef MIDI_RUNNING_STATUS_EN
  logic [7:0]      r_lastStatus;
`endif

  // First requester at or after the round-robin pointer, wrapping at NREQ.
  always_comb begin
    int cand;
    cand    = 0;
    w_found = 1'b0;
    w_pick  = '0;
    for (int k = 0; k < NREQ; k++) begin
      cand = int'(r_rrPtr) + k;
      if (cand >= NREQ) cand = cand - NREQ;
      for (int j = 0; j < NREQ; j++) begin
        if (!w_found && cand == j && bus.req[j]) begin
          w_found = 1'b1;
          w_pick  = RR_W'(j);
        end
      end
    end
  end

  always_comb begin
    w_selMsg = '0;
    w_selLen = '0;
    for (int j = 0; j < NREQ; j++) begin
      if (w_pick == RR_W'(j)) begin
        w_selMsg = bus.msg[24*j +: 24];
        w_selLen = bus.len[2*j +: 2];
      end
    end
  end

`ifdef MIDI_RUNNING_STATUS_EN
  // Only a real status byte (bit 7 set) can be elided as a repeat.
  assign w_startIdx = (w_selLen >= 2'd2 && r_lastStatus[7] &&
                       w_selMsg[23:16] == r_lastStatus) ? 2'd1 : 2'd0;
`else
  assign w_startIdx = 2'd0;
`endif

  assign w_lastByte = (r_idx == r_len - 2'd1);

  always_comb begin
    w_nextState = r_state;
    w_txWrite   = 1'b0;
    w_txData    = 8'h00;
    unique case (r_state)
      IDLE: if (w_found) w_nextState = SEND;
      SEND: begin
        // A zero-length message is finished without touching the FIFO.
        w_txWrite = ~bus.tx_full && (r_len != 2'd0);
        case (r_idx)
          2'd0:    w_txData = r_msg[23:16];
          2'd1:    w_txData = r_msg[15:8];
          default: w_txData = r_msg[7:0];
        endcase
        if (r_len == 2'd0 || (w_txWrite && w_lastByte)) w_nextState = DONE;
      end
      DONE:    w_nextState = IDLE;
      default: w_nextState = IDLE;
    endcase
  end

  always_ff @(posedge clk96) begin
    if (!rst) begin
      r_state   <= IDLE;
      r_rrPtr   <= '0;
      r_grantId <= '0;
      r_msg     <= '0;
      r_len     <= '0;
      r_idx     <= '0;
      r_done    <= '0;
    end else begin
      r_state <= w_nextState;
      for (int i = 0; i < NREQ; i++) begin
        r_done[i] <= (w_nextState == DONE) && (r_grantId == RR_W'(i));
      end
      case (r_state)
        IDLE: begin
          if (w_found) begin
            r_msg     <= w_selMsg;
            r_len     <= w_selLen;
            r_grantId <= w_pick;
            r_idx     <= w_startIdx;
          end
        end
        SEND: if (w_txWrite) r_idx <= r_idx + 2'd1;
        DONE: r_rrPtr <= (r_grantId == RR_W'(NREQ - 1)) ? '0 : r_grantId + 1'b1;
        default: ;
      endcase
    end
  end

`ifdef MIDI_RUNNING_STATUS_EN
  // Channel status is remembered, system common clears it, real-time leaves it alone.
  always_ff @(posedge clk96) begin
    if (!rst) begin
      r_lastStatus <= 8'h00;
    end else if (w_txWrite && r_idx == 2'd0) begin
      if (w_txData >= 8'h80 && w_txData <= 8'hEF)      r_lastStatus <= w_txData;
      else if (w_txData >= 8'hF0 && w_txData <= 8'hF7) r_lastStatus <= 8'h00;
    end
  end
`endif

  assign bus.done     = r_done;
  assign bus.tx_write = w_txWrite;
  assign bus.tx_data  = w_txData;
  assign bus.busy     = (r_state != IDLE);
  assign bus.grant_id = r_grantId;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter; each cycle compares {tx_write, tx_data, done, busy, grant_id}.
module tb_uart_tx_arbiter;

  logic clk96 = 1'b0;
  logic rst;
  int   errors = 0;
  int   checks = 0;

  uart_tx_arbiter_if #(.NREQ(3), .RR_W(3)) bus ();

  uart_tx_arbiter #(.NREQ(3), .RR_W(3)) dut (
    .clk96 (clk96),
    .rst   (rst),
    .bus   (bus)
  );

  always #5 clk96 = ~clk96;

  task automatic tick();
    @(posedge clk96);
    #1;
  endtask

  function automatic logic [15:0] pk(input logic wr, input logic [7:0] d,
                                     input logic [2:0] dn, input logic b,
                                     input logic [2:0] g);
    return {wr, d, dn, b, g};
  endfunction

  task automatic applyStimulus(input int src, input logic r,
                               input logic [23:0] m, input logic [1:0] l);
    bus.req[src]         = r;
    bus.msg[24*src +: 24] = m;
    bus.len[2*src +: 2]   = l;
  endtask

  // Sources drop their request once they see their done pulse.
  task automatic releaseOnDone();
    for (int s = 0; s < 3; s++) begin
      if (bus.done[s] === 1'b1) bus.req[s] = 1'b0;
    end
  endtask

  task automatic resetDut();
    bus.req     = '0;
    bus.tx_full = 1'b0;
    rst         = 1'b0;
    tick();
    tick();
    rst = 1'b1;
  endtask

  task automatic test_reset();
    logic [15:0] obs;
    bus.req = '1;
    bus.len = '1;
    bus.msg = {24'h010203, 24'h040506, 24'h070809};
    rst     = 1'b0;
    tick();
    tick();
    obs = {bus.tx_write, bus.tx_data, bus.done, bus.busy, bus.grant_id};
    checks++;
    if (obs !== pk(0, 8'h00, 3'b000, 0, 3'd0)) begin
      errors++;
      $display("[TB] FAIL reset_held got %h expected %h", obs, pk(0, 8'h00, 3'b000, 0, 3'd0));
    end
    bus.req = '0;
    rst     = 1'b1;
    tick();
    obs = {bus.tx_write, bus.tx_data, bus.done, bus.busy, bus.grant_id};
    checks++;
    if (obs !== pk(0, 8'h00, 3'b000, 0, 3'd0)) begin
      errors++;
      $display("[TB] FAIL reset_release got %h expected %h", obs, pk(0, 8'h00, 3'b000, 0, 3'd0));
    end
  endtask

  task automatic test_single();
    logic [15:0] exp [$];
    logic [15:0] obs;
    exp = '{pk(0, 8'h00, 3'b000, 0, 3'd0), pk(1, 8'h90, 3'b000, 1, 3'd0),
            pk(1, 8'h3C, 3'b000, 1, 3'd0), pk(1, 8'h64, 3'b000, 1, 3'd0),
            pk(0, 8'h00, 3'b001, 1, 3'd0), pk(0, 8'h00, 3'b000, 0, 3'd0)};
    for (int c = 0; c < exp.size(); c++) begin
      if (c == 0) applyStimulus(0, 1'b1, 24'h903C64, 2'd3);
      #1;
      obs = {bus.tx_write, bus.tx_data, bus.done, bus.busy, bus.grant_id};
      checks++;
      if (obs !== exp[c]) begin
        errors++;
        $display("[TB] FAIL single c%0d got %h expected %h (wr,data,done,busy,gid)", c, obs, exp[c]);
      end
      releaseOnDone();
      tick();
    end
  endtask

  task automatic test_two_sources();
    logic [15:0] exp [$];
    logic [15:0] obs;
    resetDut();
    exp = '{pk(0, 8'h00, 3'b000, 0, 3'd0), pk(1, 8'hA1, 3'b000, 1, 3'd0),
            pk(1, 8'hA2, 3'b000, 1, 3'd0), pk(0, 8'h00, 3'b001, 1, 3'd0),
            pk(0, 8'h00, 3'b000, 0, 3'd0), pk(1, 8'hC1, 3'b000, 1, 3'd2),
            pk(1, 8'hC2, 3'b000, 1, 3'd2), pk(0, 8'h00, 3'b100, 1, 3'd2),
            pk(0, 8'h00, 3'b000, 0, 3'd2), pk(1, 8'h11, 3'b000, 1, 3'd0),
            pk(0, 8'h00, 3'b001, 1, 3'd0), pk(0, 8'h00, 3'b000, 0, 3'd0),
            pk(1, 8'h22, 3'b000, 1, 3'd1), pk(0, 8'h00, 3'b010, 1, 3'd1),
            pk(0, 8'h00, 3'b000, 0, 3'd1)};
    for (int c = 0; c < exp.size(); c++) begin
      if (c == 0) begin
        applyStimulus(0, 1'b1, 24'hA1A200, 2'd2);
        applyStimulus(2, 1'b1, 24'hC1C200, 2'd2);
      end
      if (c == 8) begin
        applyStimulus(0, 1'b1, 24'h110000, 2'd1);
        applyStimulus(1, 1'b1, 24'h220000, 2'd1);
      end
      #1;
      obs = {bus.tx_write, bus.tx_data, bus.done, bus.busy, bus.grant_id};
      checks++;
      if (obs !== exp[c]) begin
        errors++;
        $display("[TB] FAIL two_sources c%0d got %h expected %h (wr,data,done,busy,gid)", c, obs, exp[c]);
      end
      releaseOnDone();
      tick();
    end
  endtask

  task automatic test_stall();
    logic [15:0] exp [$];
    logic [15:0] obs;
    resetDut();
    exp = '{pk(0, 8'h00, 3'b000, 0, 3'd0), pk(1, 8'h51, 3'b000, 1, 3'd1),
            pk(0, 8'h52, 3'b000, 1, 3'd1), pk(0, 8'h52, 3'b000, 1, 3'd1),
            pk(0, 8'h52, 3'b000, 1, 3'd1), pk(0, 8'h52, 3'b000, 1, 3'd1),
            pk(0, 8'h52, 3'b000, 1, 3'd1), pk(1, 8'h52, 3'b000, 1, 3'd1),
            pk(0, 8'h53, 3'b000, 1, 3'd1), pk(1, 8'h53, 3'b000, 1, 3'd1),
            pk(0, 8'h00, 3'b010, 1, 3'd1), pk(0, 8'h00, 3'b000, 0, 3'd1)};
    for (int c = 0; c < exp.size(); c++) begin
      if (c == 0) applyStimulus(1, 1'b1, 24'h515253, 2'd3);
      if (c == 2) bus.tx_full = 1'b1;
      if (c == 7) bus.tx_full = 1'b0;
      if (c == 8) bus.tx_full = 1'b1;
      if (c == 9) bus.tx_full = 1'b0;
      #1;
      obs = {bus.tx_write, bus.tx_data, bus.done, bus.busy, bus.grant_id};
      checks++;
      if (obs !== exp[c]) begin
        errors++;
        $display("[TB] FAIL stall c%0d got %h expected %h (wr,data,done,busy,gid)", c, obs, exp[c]);
      end
      releaseOnDone();
      tick();
    end
  endtask

  task automatic test_reset_mid();
    logic [15:0] exp [$];
    logic [15:0] obs;
    exp = '{pk(0, 8'h00, 3'b000, 0, 3'd1), pk(1, 8'h61, 3'b000, 1, 3'd2),
            pk(0, 8'h00, 3'b000, 0, 3'd0), pk(1, 8'h71, 3'b000, 1, 3'd1),
            pk(0, 8'h00, 3'b010, 1, 3'd1), pk(0, 8'h00, 3'b000, 0, 3'd1),
            pk(1, 8'h72, 3'b000, 1, 3'd2), pk(0, 8'h00, 3'b100, 1, 3'd2),
            pk(0, 8'h00, 3'b000, 0, 3'd2)};
    for (int c = 0; c < exp.size(); c++) begin
      if (c == 0) applyStimulus(2, 1'b1, 24'h616263, 2'd3);
      if (c == 1) begin
        rst         = 1'b0;
        bus.req[2]  = 1'b0;
      end
      if (c == 2) begin
        rst = 1'b1;
        applyStimulus(1, 1'b1, 24'h710000, 2'd1);
        applyStimulus(2, 1'b1, 24'h720000, 2'd1);
      end
      #1;
      obs = {bus.tx_write, bus.tx_data, bus.done, bus.busy, bus.grant_id};
      checks++;
      if (obs !== exp[c]) begin
        errors++;
        $display("[TB] FAIL reset_mid c%0d got %h expected %h (wr,data,done,busy,gid)", c, obs, exp[c]);
      end
      releaseOnDone();
      tick();
    end
  endtask

  task automatic test_len_zero();
    logic [15:0] exp [$];
    logic [15:0] obs;
    exp = '{pk(0, 8'h00, 3'b000, 0, 3'd2), pk(0, 8'hAB, 3'b000, 1, 3'd1),
            pk(0, 8'h00, 3'b010, 1, 3'd1), pk(0, 8'h00, 3'b000, 0, 3'd1)};
    for (int c = 0; c < exp.size(); c++) begin
      if (c == 0) applyStimulus(1, 1'b1, 24'hAB0000, 2'd0);
      #1;
      obs = {bus.tx_write, bus.tx_data, bus.done, bus.busy, bus.grant_id};
      checks++;
      if (obs !== exp[c]) begin
        errors++;
        $display("[TB] FAIL len_zero c%0d got %h expected %h (wr,data,done,busy,gid)", c, obs, exp[c]);
      end
      releaseOnDone();
      tick();
    end
  endtask

  initial begin
    rst         = 1'b0;
    bus.req     = '0;
    bus.msg     = '0;
    bus.len     = '0;
    bus.tx_full = 1'b0;
    test_reset();
    test_single();
    test_two_sources();
    test_stall();
    test_reset_mid();
    test_len_zero();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/uart_tx_arbiter.md
Name: uart_tx_arbiter

Overview:
Shares the single UART transmit byte port (data_in / write_buffer of the UART TX FIFO, clocked on clk96) between NREQ message sources, e.g. MIDI thru/echo, debug dump and status reporter.
Each source presents a complete message of 1–3 bytes. The arbiter grants sources round-robin and writes the granted message byte by byte, honouring TX FIFO full.
Messages are atomic: bytes from different sources never interleave in the serial stream.

Parameters:
NREQ, 3, number of requesters (2..8)
RR_W, 3, width of grant index; must satisfy 2**RR_W >= NREQ

Ports:
clk96  input  1  system clock, 96 MHz
rst  input  1  reset, synchronous, active-low (rst=0 resets on the next clk96 rising edge)
req  input  NREQ  per-source request; level, held high until the matching done pulse
msg  input  NREQ*24  per-source message; slice i = msg[24*i+23 : 24*i]; byte0 = [23:16], byte1 = [15:8], byte2 = [7:0]
len  input  NREQ*2  per-source byte count, slice i = len[2*i+1 : 2*i]; valid values 1..3
done  output  NREQ  one-cycle pulse to the granted source when its message has been fully written
tx_full  input  1  UART TX FIFO buffer_full
tx_write  output  1  write strobe to the UART TX FIFO
tx_data  output  8  byte to the UART TX FIFO
busy  output  1  high while a message is in progress (state SEND or DONE)
grant_id  output  RR_W  index of the current or last granted source

Behaviour:
- Reset values: state=IDLE, rr_ptr=0, grant_id=0, done=0, busy=0, tx_write=0, tx_data=0x00, byte index=0, last_status=0x00.
- State machine: IDLE -> SEND -> DONE -> IDLE.
- IDLE:
  - Search from index rr_ptr upward with wrap-around for the first i with req[i]=1.
  - If one is found: latch msg slice, len slice and grant_id=i into internal registers; set byte index=0; go to SEND on the next edge.
  - No req: stay in IDLE.
  - Latched len=0: go straight to DONE with no bytes written (error tolerance).
- SEND:
  - tx_write = (state==SEND) & ~tx_full, combinational from registers plus tx_full.
  - tx_data = latched byte[index], combinational; it is 0x00 in every state except SEND.
  - On each edge where tx_write=1: index increments. If index == latched_len-1, go to DONE.
  - tx_full=1 stalls with no write; index and state hold. There is no timeout.
- DONE:
  - done[grant_id]=1 for exactly this cycle (registered decode of state).
  - rr_ptr = grant_id+1, wrapping to 0 at NREQ.
  - Go to IDLE.
- Timing:
  - Earliest first tx_write is one cycle after req is sampled.
  - Peak throughput is len writes followed by 2 overhead cycles (DONE, IDLE) per message.
- req or msg changes after the latch are ignored until the next grant. A source dropping req mid-message still receives its done pulse.
- The same source may be re-granted immediately only if no other req is high (rr_ptr has moved past it).
- Simultaneous requests are served in rr_ptr order. No source waits more than NREQ-1 messages.
- Reset mid-message (rst=0 in SEND): the message is abandoned. tx_write falls after that edge, no done pulse is issued, and no partial-message recovery is attempted.
- tx_full rising in the same cycle as the last byte: no write occurs and the byte is retried. The write is counted only when tx_write=1 at the edge.

Optional Feature:
Macro: MIDI_RUNNING_STATUS_EN
- Defined:
  - Register last_status is updated with byte0 whenever byte0 is written and 0x80 <= byte0 <= 0xEF.
  - It is cleared to 0x00 when a written byte0 is in 0xF0..0xF7.
  - Real-time bytes 0xF8..0xFF leave it unchanged.
  - At latch time, if len>=2 and byte0 == last_status, byte0 is skipped: index starts at 1 and one fewer byte is sent.
  - last_status also resets to 0x00.
- Undefined: all bytes are always sent. The last_status register and its logic are absent.

Test Plan:
- Single source, req[0]=1, len=3, msg=0x903C64, tx_full=0 -> tx_write high for 3 consecutive cycles with bytes 0x90, 0x3C, 0x64; then done[0] pulses once; busy low again 1 cycle after done.
- req[0] and req[2] raised together with rr_ptr=0, each len=2 -> source 0's two bytes, then source 2's two bytes with no interleave; done[0] then done[2]; the next tie is won by source 0 again only after source 1/2 have been checked.
- tx_full held high 5 cycles during the second byte of a 3-byte message -> no tx_write during the stall; byte 2 is written once on release; exactly 3 writes in total.
- rst=0 asserted during SEND after the first byte -> tx_write=0, done=0, busy=0 from the next cycle; the next request after rst=1 starts from rr_ptr=0.
- len=0 with req[1]=1 -> no tx_write; done[1] pulses 2 cycles after grant.
- With MIDI_RUNNING_STATUS_EN: send 0x903C64 then 0x904000 -> bytes written are 0x90, 0x3C, 0x64, 0x40, 0x00. Then send 0xF80000 with len=1, followed by 0x904100 -> 0xF8 is written, status is retained, and the following message is sent as 0x41, 0x00.
